// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path: FSM state encoding,
// protocol byte values and the odd-parity check used at the stop bit.
`timescale 1ns/1ps
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
  localparam int         PS2_DATA_BITS  = 8;

  // A frame carries odd parity: data bits plus parity bit XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer plus de-glitch filter for one idle-high PS/2 line. The
// filtered level only follows the pin after FILTER_LEN consecutive equal
// synchronized samples; fall_o pulses for one cycle on a filtered 1->0.
`timescale 1ns/1ps
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk_board,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   fall_q, fall_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign level_o  = filt_q;
  assign fall_o   = fall_q;

  // Count how long the synchronized line has disagreed with the filtered level.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cnt_d  = '0;
    filt_d = filt_q;
    fall_d = 1'b0;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_out;
        fall_d = filt_q & ~sync_out;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer chain and filter state; lines idle high so reset presets to 1.
  always_ff @(posedge clk_board or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver. Conditions both pins, deserializes
// 11-bit frames on filtered clock falling edges, checks start/parity/stop
// and presents good bytes with a one-cycle code_valid strobe. Bad frames
// and mid-frame timeouts produce a one-cycle frame_err.
// Optional: define BREAK_FILTER_EN to suppress F0-prefixed release codes
// and E0 extension prefixes from the output stream.
`timescale 1ns/1ps
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_board,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       scan_q, scan_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
`ifdef BREAK_FILTER_EN
  logic             break_q, break_d;
`endif

  logic clk_level_unused;
  logic data_fall_unused;
  logic fall_edge;
  logic data_f;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_board (clk_board),
    .rst       (rst),
    .line_i    (ps2_clk),
    .level_o   (clk_level_unused),
    .fall_o    (fall_edge)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk_board (clk_board),
    .rst       (rst),
    .line_i    (ps2_data),
    .level_o   (data_f),
    .fall_o    (data_fall_unused)
  );

  assign scan_code  = scan_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);

  // Frame FSM, timeout watchdog and output strobe generation.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    scan_d    = scan_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef BREAK_FILTER_EN
    break_d   = break_q;
`endif

    if (state_q == IDLE || fall_edge) tmo_d = '0;
    else                              tmo_d = tmo_q + TMO_W'(1);

    // Expiry wins over a coincident clock edge.
    if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
`ifdef BREAK_FILTER_EN
      break_d = 1'b0;
`endif
    end else if (fall_edge) begin
      case (state_q)
        IDLE: begin
          if (!data_f) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_f;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_f;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_f && odd_parity_ok(shift_q, parity_q)) begin
`ifdef BREAK_FILTER_EN
            if (break_q) begin
              break_d = 1'b0;
            end else if (shift_q == PS2_BREAK_CODE) begin
              break_d = 1'b1;
            end else if (shift_q != PS2_EXT_CODE) begin
              scan_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            scan_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
`ifdef BREAK_FILTER_EN
            break_d = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Receiver state registers; reset discards any partial frame silently.
  always_ff @(posedge clk_board or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      scan_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef BREAK_FILTER_EN
      break_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      scan_q    <= scan_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef BREAK_FILTER_EN
      break_q   <= break_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: stimulus pushes expected events from a
// byte-level reference model; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int TMO  = 200;
  localparam int H    = 12;   // PS/2 half period in clk_board cycles

  logic       clk_board = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_scan;
  bit         break_m;
  int         checks = 0;
  int         errors = 0;
  int         n_valid = 0;

  ps2_rx_frame #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_board  (clk_board),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk_board = ~clk_board;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the receiver should report for one decoded frame.
  task automatic model_frame(input logic [7:0] b, input bit good);
    exp_t e;
    if (!good) begin
      e.is_err = 1'b1; e.code = 8'h00;
      exp_q.push_back(e);
      break_m = 1'b0;
      return;
    end
`ifdef BREAK_FILTER_EN
    if (break_m) begin
      break_m = 1'b0;
      return;
    end
    if (b == 8'hF0) begin
      break_m = 1'b1;
      return;
    end
    if (b == 8'hE0) return;
`endif
    e.is_err = 1'b0; e.code = b;
    exp_q.push_back(e);
    exp_scan = b;
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk_board);
    ps2_data = v;
    repeat (H) @(negedge clk_board);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk_board);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^b) ^ bad_par;
    model_frame(b, !bad_par && !bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(!bad_stop);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk_board);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_board);
      n++;
    end
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_board) begin
    exp_t e;
    if (!rst) begin
      if (code_valid && frame_err) check("valid_err_exclusive", 1, 0);
      if (code_valid) n_valid++;
      if (code_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {code_valid, frame_err}, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_err", frame_err, e.is_err);
          if (!e.is_err) check("scan_code", scan_code, e.code);
        end
      end
    end
  end

  initial begin
    int  cnt;
    int  v0;
    bit  busy_seen;
    logic [7:0] b;
    logic [7:0] seq[4];

    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    exp_scan = 8'h00;
    break_m  = 1'b0;
    rst      = 1'b1;
    #1;
    check("reset_scan_code", scan_code, 8'h00);
    check("reset_code_valid", code_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    repeat (4) @(negedge clk_board);
    rst = 1'b0;
    repeat (10) @(negedge clk_board);

    // Directed good frame then same-shape frame with inverted parity.
    send_frame(8'h79, 1'b0, 1'b0);
    wait_drain();
    check("scan_after_79", scan_code, 8'h79);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_drain();
    check("scan_kept_after_parity_err", scan_code, exp_scan);

    // Clock stops after 5 data bits: timeout abort.
    model_frame(8'h00, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk_board);
    ps2_data = 1'b0;
    repeat (H) @(negedge clk_board);
    ps2_clk = 1'b0;
    cnt = 0;
    while (!frame_err && cnt < TMO + 100) begin
      @(negedge clk_board);
      cnt++;
      if (cnt == H) begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
      end
    end
    check("timeout_latency", cnt, TMO + SYNC + FILT + 1);
    @(negedge clk_board);
    check("busy_after_timeout", busy, 0);
    wait_drain();
    send_frame(8'h66, 1'b0, 1'b0);
    wait_drain();

    // 2-cycle low glitch on the clock pin while idle.
    @(negedge clk_board);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk_board);
    ps2_clk = 1'b1;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk_board);
      if (busy) busy_seen = 1'b1;
    end
    check("glitch_no_busy", busy_seen, 0);

    // Break-code sequence.
    seq[0] = 8'h66; seq[1] = 8'hF0; seq[2] = 8'h66; seq[3] = 8'h29;
    v0 = n_valid;
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b0, 1'b0);
    wait_drain();
`ifdef BREAK_FILTER_EN
    check("break_seq_pulses", n_valid - v0, 2);
`else
    check("break_seq_pulses", n_valid - v0, 4);
`endif
    check("scan_after_break_seq", scan_code, 8'h29);

    // Reset after data bit 4 of a frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    check("busy_mid_frame", busy, 1);
    @(negedge clk_board);
    rst = 1'b1;
    #1;
    check("midrst_scan_code", scan_code, 8'h00);
    check("midrst_code_valid", code_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_busy", busy, 0);
    exp_scan = 8'h00;
    break_m  = 1'b0;
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    repeat (3) @(negedge clk_board);
    rst = 1'b0;
    repeat (10) @(negedge clk_board);
    send_frame(8'h5A, 1'b0, 1'b0);
    wait_drain();
    check("scan_after_reset_5A", scan_code, 8'h5A);

    // Randomized frames with occasional parity or stop corruption.
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 20)) @(negedge clk_board);
    end
    wait_drain();
    check("final_scan_code", scan_code, exp_scan);
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Upstream front end of the keyboard instruction path. It synchronizes and de-glitches the raw PS/2 clock and data lines and deserializes 11-bit device-to-host frames. It checks start, parity and stop bits, then presents each good scan code on a byte bus with a single-cycle valid strobe. The downstream instruction decoder consumes that byte/strobe pair and never touches the PS/2 pins.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each PS/2 input before filtering (minimum 2).
FILTER_LEN, 4, consecutive identical samples required before the filtered line changes.
TIMEOUT_CYCLES, 50000, clk_board cycles without a falling edge while mid-frame before abort (1 ms at 50 MHz).

Ports:
clk_board  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-high reset.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk_board, idles high.
ps2_data  input  1  raw PS/2 data pin, asynchronous to clk_board, idles high.
scan_code  output  8  last good received byte, LSB = first data bit.
code_valid  output  1  one-cycle pulse; scan_code is new and valid in that cycle.
frame_err  output  1  one-cycle pulse on bad start/parity/stop or timeout.
busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst=1): state IDLE; scan_code=8'h00; code_valid=0; frame_err=0; busy=0; sync and filter registers preset to 1 (idle-high lines); bit counter, shift register and timeout counter cleared. Reset mid-frame discards the partial frame and emits no pulse.
- Line conditioning: each pin passes through SYNC_STAGES flops. The filtered value changes only after FILTER_LEN consecutive equal synchronized samples. fall_edge is a one-cycle pulse when filtered clk goes 1->0. All frame sampling uses the filtered data value in the fall_edge cycle.
- FSM, advancing only on fall_edge unless noted:
  - IDLE: data==0 -> DATA, bit_cnt=0. data==1 -> stay in IDLE (spurious edge ignored, no error).
  - DATA: shift data into bit position bit_cnt (LSB first) and increment bit_cnt. After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: good frame = stop bit 1 and XOR of the 8 data bits plus the parity bit equal to 1 (odd parity). On a good frame, scan_code loads the shifted byte and code_valid pulses in the next cycle. Otherwise frame_err pulses in the next cycle and scan_code is unchanged. Always -> IDLE.
- Timeout: the counter resets on every fall_edge and holds at 0 in IDLE. Outside IDLE it increments each cycle. At TIMEOUT_CYCLES-1: -> IDLE, frame_err pulses next cycle, no code_valid.
- Latency: code_valid rises exactly 1 cycle after the fall_edge cycle of the stop bit. Pin-to-fall_edge delay is SYNC_STAGES+FILTER_LEN cycles.
- code_valid and frame_err are never high in the same cycle. Each is high for exactly one cycle per event.
- scan_code holds its value until the next good frame.
- No backpressure: the downstream block must accept code_valid in the cycle it is asserted.
- A fall_edge in the same cycle as the timeout expiry is treated as the timeout: frame aborted, edge ignored.

Optional Feature:
BREAK_FILTER_EN
- Defined: a good byte 8'hF0 sets break_pending and is not emitted. The next good byte clears break_pending and is not emitted, so key releases are suppressed. A good byte 8'hE0 is never emitted; the byte that follows is handled normally. frame_err, timeout and reset all clear break_pending.
- Undefined: every good byte, including F0 and E0, is emitted with code_valid. No break_pending register exists.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - constants PS2_BREAK_CODE=8'hF0, PS2_EXT_CODE=8'hE0, PS2_DATA_BITS=8;
  - a function for odd-parity check.
- Sub-module ps2_line_filter, instantiated twice (clk and data): synchronizer plus FILTER_LEN de-glitch. The clock instance also produces the fall_edge pulse. The FSM, shift register and timeout stay in ps2_rx_frame.

Test Plan:
- Frame for 8'h79 (bits 0,1,0,0,1,1,1,1,0 after start, parity 0, stop 1) at 12.5 kHz PS/2 clock -> one code_valid, scan_code=8'h79, frame_err stays 0.
- 8'h5A sent with parity bit inverted -> frame_err pulse, no code_valid, scan_code retains the previous 8'h79.
- Clock stops after 5 data bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last edge, busy drops. A following good 8'h66 is received correctly.
- 2-cycle low glitch on ps2_clk with FILTER_LEN=4 -> no fall_edge, no state change, busy stays 0.
- With BREAK_FILTER_EN, sequence 66, F0, 66, 29 -> exactly two code_valid pulses (8'h66 then 8'h29). Without the macro, the same sequence gives four pulses.
- rst asserted after bit 4 of a frame -> all outputs 0 immediately, no pulse. The next complete frame for 8'h5A is received correctly.
